cast_op_pipe: RTL

//  Pipelined, runtime-selectable integer cast unit for HLS datapaths: ZEXT, SEXT, TRUNC, SAT_TRUNC.

---
 rtl/cast_op_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cast_op_pipe.sv
// Integer cast unit (ZEXT/SEXT/TRUNC/SAT_TRUNC) with a per-transaction opcode and a saturation flag.
// Latency: Latency cycles from accept to out_valid. Stall chain: 1/cycle when drained, enable=0 freezes every stage.
module cast_op_pipe #(
   parameter int ParamBitWidth  = 32,
   parameter int ReturnBitWidth = 32,
   parameter int Latency        = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                op,
   input  logic [ParamBitWidth-1:0]  lhs,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ReturnBitWidth-1:0] ret,
   output logic                      sat
);
   localparam int P = ParamBitWidth;
   localparam int R = ReturnBitWidth;

   typedef struct packed {
      logic [R-1:0] ret;
      logic         sat;
   } res_t;

   generate
      if (Latency < 1 || Latency > 4) begin : g_bad_latency
         $error("cast_op_pipe: Latency must be in 1..4");
      end
   endgenerate

   logic [R-1:0] ext_ret;
   logic [R-1:0] sat_ret;
   logic         sat_hit;
   res_t         cast_res;

   // Signed resize covers SEXT and TRUNC in both directions: it truncates when R<P.
   assign ext_ret = R'($signed(lhs));

   generate
      if (R < P) begin : g_narrow
         localparam logic [P-1:0] SMAX = {{(P-R+1){1'b0}}, {(R-1){1'b1}}};
         localparam logic [P-1:0] SMIN = {{(P-R+1){1'b1}}, {(R-1){1'b0}}};
         always_comb begin
            sat_hit = 1'b0;
            sat_ret = ext_ret;
            if ($signed(lhs) > $signed(SMAX)) begin
               sat_hit = 1'b1;
               sat_ret = R'(SMAX);
            end else if ($signed(lhs) < $signed(SMIN)) begin
               sat_hit = 1'b1;
               sat_ret = R'(SMIN);
            end
         end
      end else begin : g_wide
         assign sat_hit = 1'b0;
         assign sat_ret = ext_ret;
      end
   endgenerate

   always_comb begin
      cast_res.ret = ext_ret;
      cast_res.sat = 1'b0;
      case (op)
         2'd0: cast_res.ret = R'(lhs);
         2'd3: begin
            cast_res.ret = sat_ret;
            cast_res.sat = sat_hit;
         end
         default: ;
      endcase
   end

   logic [Latency-1:0] stg_vld;
   logic [Latency-1:0] adv;
   logic [Latency-1:0] src_vld;
   res_t               stg_dat [Latency];
   res_t               src_dat [Latency];

   // A stage advances when any stage from it to the output is empty, or the consumer takes the result.
   always_comb begin
      logic full_tail;
      full_tail = 1'b1;
      adv       = '0;
      for (int k = Latency - 1; k >= 0; k--) begin
         full_tail = full_tail & stg_vld[k];
         adv[k]    = enable & (out_ready | !full_tail);
      end
   end

   always_comb begin
      src_vld[0] = in_valid;
      src_dat[0] = cast_res;
      for (int k = 1; k < Latency; k++) begin
         src_vld[k] = stg_vld[k-1];
         src_dat[k] = stg_dat[k-1];
      end
   end

   assign in_ready = reset_n & adv[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stg_vld <= '0;
         for (int k = 0; k < Latency; k++) stg_dat[k] <= '0;
      end else begin
         for (int k = 0; k < Latency; k++) begin
            if (adv[k]) begin
               stg_vld[k] <= src_vld[k];
               if (src_vld[k]) stg_dat[k] <= src_dat[k];
            end
         end
      end
   end

   assign out_valid = stg_vld[Latency-1];
   assign ret       = stg_dat[Latency-1].ret;
   assign sat       = stg_dat[Latency-1].sat;
endmodule
